// File: rtl/bus_cycle_ctrl_pkg.sv
// Shared types and defaults for the CPU bus cycle controller: FSM states,
// decoded address regions and default wait/timeout settings.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT,
    ST_ACK,
    ST_BERR
  } bus_state_t;

  typedef enum logic [1:0] {
    REGION_NONE,
    REGION_ROM,
    REGION_RAM,
    REGION_IO
  } region_t;

  localparam int unsigned DEF_ROM_WAIT     = 1;
  localparam int unsigned DEF_RAM_WAIT     = 0;
  localparam int unsigned DEF_IO_WAIT      = 2;
  localparam int unsigned DEF_BERR_TIMEOUT = 64;

  localparam logic [3:0] ADDR_ROM = 4'h0;
  localparam logic [3:0] ADDR_RAM = 4'h1;
  localparam logic [3:0] ADDR_IO  = 4'hF;

  function automatic region_t decode_region(input logic [3:0] addr_hi);
    region_t r;
    case (addr_hi)
      ADDR_ROM: r = REGION_ROM;
      ADDR_RAM: r = REGION_RAM;
      ADDR_IO:  r = REGION_IO;
      default:  r = REGION_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// CPU-side bus signals of the cycle controller; master = CPU/bench side,
// slave = controller side.
interface bus_cycle_ctrl_if;
  logic       as_n;
  logic       uds_n;
  logic       lds_n;
  logic       rw;
  logic [3:0] addr_hi;
  logic       io_wait;
  logic       rom_en;
  logic       ram_en;
  logic       io_en;
  logic       dtack_n;
  logic       berr_n;

  modport master (
    output as_n, uds_n, lds_n, rw, addr_hi, io_wait,
    input  rom_en, ram_en, io_en, dtack_n, berr_n
  );

  modport slave (
    input  as_n, uds_n, lds_n, rw, addr_hi, io_wait,
    output rom_en, ram_en, io_en, dtack_n, berr_n
  );
endinterface

// File: rtl/bus_cycle_ctrl_watchdog.sv
// Bus cycle watchdog: counts cycles while run is high, saturating, and flags
// expiry on the cycle whose edge brings the count to TIMEOUT.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int unsigned CW    = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != CW'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  // Holding LIMIT means the coming edge is the TIMEOUT-th non-idle cycle.
  assign expired = run && (count >= CW'(LIMIT));

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Bus cycle controller: decodes A23..A20 into ROM/RAM/IO enables, inserts
// per-region wait states, and answers with DTACK or BERR (incl. watchdog).
module bus_cycle_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned ROM_WAIT     = DEF_ROM_WAIT,
  parameter int unsigned RAM_WAIT     = DEF_RAM_WAIT,
  parameter int unsigned IO_WAIT      = DEF_IO_WAIT,
  parameter int unsigned BERR_TIMEOUT = DEF_BERR_TIMEOUT
) (
  input logic             clk,
  input logic             rst_n,
  bus_cycle_ctrl_if.slave bus
);

  localparam int unsigned MAX_WAIT =
    (ROM_WAIT > RAM_WAIT) ? ((ROM_WAIT > IO_WAIT) ? ROM_WAIT : IO_WAIT)
                          : ((RAM_WAIT > IO_WAIT) ? RAM_WAIT : IO_WAIT);
  localparam int unsigned WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  bus_state_t     state;
  region_t        region_q;
  logic           rw_q;
  logic [WCW-1:0] wcnt;
  logic           armed;
  logic           strobe;
  logic           wd_clear;
  logic           wd_expired;

  function automatic logic [WCW-1:0] wait_load(input region_t r);
    logic [WCW-1:0] w;
    case (r)
      REGION_ROM: w = WCW'(ROM_WAIT);
      REGION_RAM: w = WCW'(RAM_WAIT);
      REGION_IO:  w = WCW'(IO_WAIT);
      default:    w = '0;
    endcase
    return w;
  endfunction

  assign strobe   = !bus.uds_n || !bus.lds_n;
  assign wd_clear = (state == ST_IDLE);

  bus_watchdog #(
    .TIMEOUT (BERR_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .run     (!wd_clear),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      region_q    <= REGION_NONE;
      rw_q        <= 1'b1;
      wcnt        <= '0;
      armed       <= 1'b0;
      bus.rom_en  <= 1'b0;
      bus.ram_en  <= 1'b0;
      bus.io_en   <= 1'b0;
      bus.dtack_n <= 1'b1;
      bus.berr_n  <= 1'b1;
    end else begin
      // A cycle already running when reset lifted must see as_n high first.
      if (bus.as_n) armed <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (!bus.as_n && strobe && armed) begin
            state    <= ST_DECODE;
            region_q <= decode_region(bus.addr_hi);
            rw_q     <= bus.rw;
          end
        end

        ST_DECODE: begin
          if (bus.as_n) begin
            state <= ST_IDLE;
          end else if (wd_expired) begin
            state      <= ST_BERR;
            bus.berr_n <= 1'b0;
          end else if (region_q == REGION_NONE ||
                       (region_q == REGION_ROM && !rw_q)) begin
            // Decode errors show berr_n from the first BERR-state edge.
            state <= ST_BERR;
          end else begin
            state      <= ST_WAIT;
            wcnt       <= wait_load(region_q);
            bus.rom_en <= (region_q == REGION_ROM);
            bus.ram_en <= (region_q == REGION_RAM);
            bus.io_en  <= (region_q == REGION_IO);
          end
        end

        ST_WAIT: begin
          if (bus.as_n) begin
            state <= ST_IDLE;
            {bus.rom_en, bus.ram_en, bus.io_en} <= 3'b000;
          end else if (wd_expired) begin
            state      <= ST_BERR;
            bus.berr_n <= 1'b0;
            {bus.rom_en, bus.ram_en, bus.io_en} <= 3'b000;
          end else if (wcnt == '0) begin
            if (!(region_q == REGION_IO && bus.io_wait)) begin
              state       <= ST_ACK;
              bus.dtack_n <= 1'b0;
            end
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end

        ST_ACK: begin
          if (bus.as_n) begin
            state       <= ST_IDLE;
            bus.dtack_n <= 1'b1;
            {bus.rom_en, bus.ram_en, bus.io_en} <= 3'b000;
          end
        end

        ST_BERR: begin
          if (bus.as_n) begin
            state      <= ST_IDLE;
            bus.berr_n <= 1'b1;
          end else begin
            bus.berr_n <= 1'b0;
          end
        end

        default: begin
          state       <= ST_IDLE;
          bus.dtack_n <= 1'b1;
          bus.berr_n  <= 1'b1;
          {bus.rom_en, bus.ram_en, bus.io_en} <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl: a vector table of full bus cycles plus
// hand sequences for long IO wait, timeout, mid-cycle reset and abort.
module tb_bus_cycle_ctrl;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  bus_cycle_ctrl_if bif ();

  bus_cycle_ctrl #(
    .ROM_WAIT     (1),
    .RAM_WAIT     (0),
    .IO_WAIT      (2),
    .BERR_TIMEOUT (64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {rom_en, ram_en, io_en, dtack_n, berr_n}.
  logic [4:0] obs;
  assign obs = {bif.rom_en, bif.ram_en, bif.io_en, bif.dtack_n, bif.berr_n};

  typedef struct packed {
    logic       as_n;
    logic       uds_n;
    logic       lds_n;
    logic       rw;
    logic [3:0] addr;
    logic       io_wait;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic drive(input logic as_n, input logic uds_n, input logic lds_n,
                       input logic rw, input logic [3:0] addr, input logic iow);
    bif.as_n    = as_n;
    bif.uds_n   = uds_n;
    bif.lds_n   = lds_n;
    bif.rw      = rw;
    bif.addr_hi = addr;
    bif.io_wait = iow;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b (rom,ram,io,dtack_n,berr_n)",
                  name, obs, exp);
  endtask

  task automatic add(input logic as_n, input logic uds_n, input logic lds_n,
                     input logic rw, input logic [3:0] addr, input logic iow,
                     input logic [4:0] exp);
    vecs.push_back(vec_t'{as_n, uds_n, lds_n, rw, addr, iow, exp});
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;

    // RAM read, both strobes
    add(1, 0, 0, 1, 4'h1, 0, 5'b00011);
    add(0, 0, 0, 1, 4'h1, 0, 5'b00011);
    add(0, 0, 0, 1, 4'h1, 0, 5'b01011);
    add(0, 0, 0, 1, 4'h1, 0, 5'b01001);
    add(0, 0, 0, 1, 4'h1, 0, 5'b01001);
    add(1, 1, 1, 1, 4'h1, 0, 5'b00011);
    // RAM write, lower strobe only
    add(0, 1, 0, 0, 4'h1, 0, 5'b00011);
    add(0, 1, 0, 0, 4'h1, 0, 5'b01011);
    add(0, 1, 0, 0, 4'h1, 0, 5'b01001);
    add(1, 1, 1, 0, 4'h1, 0, 5'b00011);
    // Unmapped 0x5 read
    add(0, 0, 0, 1, 4'h5, 0, 5'b00011);
    add(0, 0, 0, 1, 4'h5, 0, 5'b00011);
    add(0, 0, 0, 1, 4'h5, 0, 5'b00010);
    add(0, 0, 0, 1, 4'h5, 0, 5'b00010);
    add(1, 1, 1, 1, 4'h5, 0, 5'b00011);
    // ROM write is a bus error
    add(0, 0, 0, 0, 4'h0, 0, 5'b00011);
    add(0, 0, 0, 0, 4'h0, 0, 5'b00011);
    add(0, 0, 0, 0, 4'h0, 0, 5'b00010);
    add(1, 1, 1, 0, 4'h0, 0, 5'b00011);
    // Unmapped 0xE (neighbour of IO) upper strobe only
    add(0, 0, 1, 1, 4'hE, 0, 5'b00011);
    add(0, 0, 1, 1, 4'hE, 0, 5'b00011);
    add(0, 0, 1, 1, 4'hE, 0, 5'b00010);
    add(1, 1, 1, 1, 4'hE, 0, 5'b00011);
    // ROM read, one wait state
    add(0, 0, 0, 1, 4'h0, 0, 5'b00011);
    add(0, 0, 0, 1, 4'h0, 0, 5'b10011);
    add(0, 0, 0, 1, 4'h0, 0, 5'b10011);
    add(0, 0, 0, 1, 4'h0, 0, 5'b10001);
    add(1, 1, 1, 1, 4'h0, 0, 5'b00011);
    // IO read, two wait states, io_wait low
    add(0, 0, 0, 1, 4'hF, 0, 5'b00011);
    add(0, 0, 0, 1, 4'hF, 0, 5'b00111);
    add(0, 0, 0, 1, 4'hF, 0, 5'b00111);
    add(0, 0, 0, 1, 4'hF, 0, 5'b00111);
    add(0, 0, 0, 1, 4'hF, 0, 5'b00101);
    add(1, 1, 1, 1, 4'hF, 0, 5'b00011);
    // as_n low without data strobes starts nothing
    add(0, 1, 1, 1, 4'h1, 0, 5'b00011);
    add(0, 1, 1, 1, 4'h1, 0, 5'b00011);
    add(1, 1, 1, 1, 4'h1, 0, 5'b00011);

    drive(1, 1, 1, 1, 4'h0, 0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("reset_async", 5'b00011);
    step();
    check("reset_hold", 5'b00011);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].as_n, vecs[i].uds_n, vecs[i].lds_n, vecs[i].rw,
            vecs[i].addr, vecs[i].io_wait);
      step();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // IO write with io_wait high for 10 cycles
    drive(0, 0, 0, 0, 4'hF, 1);
    step();
    check("iow_decode", 5'b00011);
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("iow_hold%0d", k), 5'b00111);
    end
    bif.io_wait = 1'b0;
    step();
    check("iow_ack", 5'b00101);
    bif.as_n = 1'b1;
    step();
    check("iow_release", 5'b00011);

    // Watchdog: IO read with io_wait stuck high
    drive(0, 0, 0, 1, 4'hF, 1);
    step();
    check("to_decode", 5'b00011);
    for (int k = 1; k <= 63; k++) begin
      step();
      check($sformatf("to_wait%0d", k), 5'b00111);
    end
    step();
    check("to_berr64", 5'b00010);
    step();
    check("to_berr_hold", 5'b00010);
    drive(1, 1, 1, 1, 4'hF, 0);
    step();
    check("to_release", 5'b00011);

    // Reset pulse during ROM wait, as_n stays low afterwards
    drive(0, 0, 0, 1, 4'h0, 0);
    step();
    step();
    check("rst_pre", 5'b10011);
    #2 rst_n = 1'b0;
    #1 check("rst_mid", 5'b00011);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rst_ignore%0d", k), 5'b00011);
    end
    bif.as_n = 1'b1;
    step();
    check("rst_rearm", 5'b00011);

    // Abort during ROM wait, then a clean ROM read
    drive(0, 0, 0, 1, 4'h0, 0);
    step();
    step();
    check("abort_en", 5'b10011);
    bif.as_n = 1'b1;
    step();
    check("abort_idle", 5'b00011);
    step();
    check("abort_quiet", 5'b00011);
    drive(0, 0, 0, 1, 4'h0, 0);
    step();
    check("rom2_c0", 5'b00011);
    step();
    check("rom2_c1", 5'b10011);
    step();
    check("rom2_c2", 5'b10011);
    step();
    check("rom2_c3", 5'b10001);
    bif.as_n = 1'b1;
    step();
    check("rom2_release", 5'b00011);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bus_cycle_ctrl.md
BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 SHALL have parameter ROM_WAIT, default 1, meaning wait-state cycles before DTACK for ROM.
REQ-002 SHALL have parameter RAM_WAIT, default 0, meaning wait-state cycles before DTACK for RAM.
REQ-003 SHALL have parameter IO_WAIT, default 2, meaning wait-state cycles before DTACK for I/O ports.
REQ-004 SHALL have parameter BERR_TIMEOUT, default 64, meaning cycles from AS low to forced bus error.
REQ-005 clk  input  1  system clock; all logic rising-edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 as_n  input  1  CPU address strobe, active low, synchronous to clk.
REQ-008 uds_n, lds_n  input  1 each  upper/lower data strobes, active low.
REQ-009 rw  input  1  1 = read, 0 = write.
REQ-010 addr_hi  input  4  CPU A23..A20.
REQ-011 io_wait  input  1  I/O slave extends wait while high.
REQ-012 rom_en, ram_en, io_en  output  1 each  slave enables, active high, at most one high.
REQ-013 dtack_n  output  1  data acknowledge to CPU, active low.
REQ-014 berr_n  output  1  bus error to CPU, active low.

Function
REQ-015 SHALL decode addr_hi: 0x0 ROM, 0x1 RAM, 0xF IO, all others unmapped.
REQ-016 SHALL implement states IDLE, DECODE, WAIT, ACK, BERR.
REQ-017 IDLE: as_n low and (uds_n low or lds_n low) -> DECODE; region and rw latched at that edge.
REQ-018 DECODE: unmapped region, or ROM with rw=0 -> BERR; else assert region enable and load wait counter with region's *_WAIT -> WAIT.
REQ-019 WAIT: decrement counter per cycle; at zero, and io_wait low for IO region -> ACK.
REQ-020 Wait value 0 SHALL give ACK on the cycle after DECODE (dtack_n low 2 cycles after as_n sampled low).
REQ-021 ACK: dtack_n low, enable held, until as_n sampled high -> IDLE; dtack_n and enable deassert at that edge.
REQ-022 BERR: berr_n low, no enable, until as_n sampled high -> IDLE.
REQ-023 Watchdog SHALL count cycles while state is not IDLE; reaching BERR_TIMEOUT in DECODE or WAIT -> BERR, enable dropped same edge.
REQ-024 as_n sampled high in DECODE or WAIT (aborted cycle) SHALL return to IDLE with no dtack_n/berr_n pulse.
REQ-025 dtack_n and berr_n SHALL never be low simultaneously; watchdog expiry in ACK is ignored.
REQ-026 A new cycle SHALL NOT start until as_n has been sampled high at least once after ACK/BERR.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-028 Counters SHALL saturate, never wrap; widths sized from parameters via $clog2.

Reset
REQ-029 rst_n low SHALL force state IDLE, counters 0, rom_en/ram_en/io_en 0, dtack_n 1, berr_n 1, immediately, including mid-cycle.
REQ-030 After rst_n release, a cycle already in progress (as_n low) SHALL be ignored until as_n is sampled high.

Structure
REQ-031 Package bus_pkg SHALL hold the state enum, region codes (REGION_ROM, REGION_RAM, REGION_IO, REGION_NONE) and default wait/timeout constants.
REQ-032 Watchdog SHALL be sub-module bus_watchdog (clear, run, expired outputs); decode and FSM stay in bus_cycle_ctrl.

Verification
REQ-033 RAM read: addr_hi=0x1, rw=1, as_n low at cycle 0 -> ram_en high cycle 1, dtack_n low cycle 2, both released the edge after as_n rises.
REQ-034 IO write, io_wait high 10 cycles: addr_hi=0xF -> io_en high, dtack_n low exactly one cycle after io_wait falls (wait count already expired).
REQ-035 Unmapped addr_hi=0x5, and ROM write addr_hi=0x0 rw=0 -> berr_n low cycle 2, no enable ever high, dtack_n stays 1.
REQ-036 Timeout: IO access, io_wait held high -> berr_n low 64 cycles after as_n low, io_en dropped same edge.
REQ-037 rst_n pulsed low during WAIT -> all outputs at reset values within the same cycle; as_n still low after release -> no enable, no dtack_n.
REQ-038 Abort: as_n rises during ROM WAIT -> IDLE, no dtack_n/berr_n pulse; next ROM read completes with dtack_n at cycle 3.
